// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit pipelined core: control word layout,
// ID/EX stage state encoding and the pipeline-register select codes.
package core_pkg;

  // Width of the packed control word carried from ID into EX
  localparam int CTRL_W = 9;

  // Bit positions inside the control word; alu_op occupies [C_ALU_OP +: C_ALU_OP_W]
  localparam int C_ALU_OP     = 0;
  localparam int C_ALU_OP_W   = 4;
  localparam int C_ALU_SRC    = 4;
  localparam int C_MEM_TO_REG = 5;
  localparam int C_MEM_WRITE  = 6;
  localparam int C_MEM_READ   = 7;
  localparam int C_REG_WRITE  = 8;

  // ID/EX stage state: RUN in normal flow, FREEZE while memory is busy
  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_t;

  // What the EX pipeline register does on the next edge
  typedef enum logic [1:0] {
    SEL_LOAD   = 2'd0,
    SEL_BUBBLE = 2'd1,
    SEL_HOLD   = 2'd2
  } ex_sel_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and the priority decode that picks what the
// ID/EX register does this cycle: memory busy, then branch flush, then
// load-use bubble, then normal load.
module hazard_detect
  import core_pkg::*;
#(
  parameter int RA_W = 32
) (
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_branch_taken,
  input  logic            mem_busy,
  output ex_sel_t         sel,
  output logic            stall,
  output logic            if_id_flush,
  output logic            stall_evt,
  output logic            flush_evt
);

  logic lu;

  // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time
  always_comb begin
    lu = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
         ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

  // Priority decode; a taken branch squashes the hazard so only the flush is counted
  always_comb begin
    sel         = SEL_LOAD;
    stall       = 1'b0;
    if_id_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (mem_busy) begin
      sel   = SEL_HOLD;
      stall = 1'b1;
    end else if (ex_branch_taken) begin
      sel         = SEL_BUBBLE;
      if_id_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (lu) begin
      sel       = SEL_BUBBLE;
      stall     = 1'b1;
      stall_evt = 1'b1;
    end
  end

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, stopping at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded operands and control into EX,
// inserts bubbles on load-use hazards and taken branches, holds while the
// memory stage is busy, and counts stall and flush events.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int RA_W  = 32,
  parameter int D_W   = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [D_W-1:0]    id_rs_data,
  input  logic [D_W-1:0]    id_rt_data,
  input  logic [D_W-1:0]    id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              ex_valid,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic [D_W-1:0]    ex_rs_data,
  output logic [D_W-1:0]    ex_rt_data,
  output logic [D_W-1:0]    ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_t  state;
  ex_sel_t sel;
  logic    stall_evt;
  logic    flush_evt;

  hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard (
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_ctrl[C_MEM_READ]),
    .ex_rd           (ex_rd),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .sel             (sel),
    .stall           (stall),
    .if_id_flush     (if_id_flush),
    .stall_evt       (stall_evt),
    .flush_evt       (flush_evt)
  );

  // Track whether the pipe is frozen by memory; the release cycle already follows RUN rules
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mem_busy)  state <= FREEZE;
        FREEZE:  if (!mem_busy) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // EX pipeline register: load from ID, take a zeroed bubble, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      case (sel)
        SEL_LOAD: begin
          ex_valid   <= id_valid;
          ex_rs      <= id_rs;
          ex_rt      <= id_rt;
          ex_rd      <= id_rd;
          ex_rs_data <= id_rs_data;
          ex_rt_data <= id_rt_data;
          ex_imm     <= id_imm;
          ex_ctrl    <= id_ctrl;
        end
        SEL_BUBBLE: begin
          ex_valid   <= 1'b0;
          ex_rs      <= '0;
          ex_rt      <= '0;
          ex_rd      <= '0;
          ex_rs_data <= '0;
          ex_rt_data <= '0;
          ex_imm     <= '0;
          ex_ctrl    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_evt),
    .count (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table for the hazard, branch,
// freeze and reset sequences, a counter saturation run, then randomized
// traffic against a cycle-level reference model.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int RA_W  = 32;
  localparam int D_W   = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [CTRL_W-1:0] LD  = CTRL_W'((1 << C_REG_WRITE) | (1 << C_MEM_READ) |
                                              (1 << C_MEM_TO_REG) | (1 << C_ALU_SRC));
  localparam logic [CTRL_W-1:0] ALU = CTRL_W'((1 << C_REG_WRITE) | (2 << C_ALU_OP));

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [RA_W-1:0]   id_rs, id_rt, id_rd;
  logic [D_W-1:0]    id_rs_data, id_rt_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic              ex_valid;
  logic [RA_W-1:0]   ex_rs, ex_rt, ex_rd;
  logic [D_W-1:0]    ex_rs_data, ex_rt_data, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              stall, if_id_flush;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(
    .RA_W(RA_W), .D_W(D_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall(stall), .if_id_flush(if_id_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: what EX should hold, and the event totals so far
  logic              m_valid;
  logic [RA_W-1:0]   m_rs, m_rt, m_rd;
  logic [D_W-1:0]    m_rsd, m_rtd, m_imm;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_sc, m_fc;

  typedef struct {
    logic              rst, v;
    logic [7:0]        rs, rt, rd, imm;
    logic [CTRL_W-1:0] ctrl;
    logic              br, busy, chk_comb, e_stall, e_flush, e_valid;
    logic [7:0]        e_rs, e_rd, e_imm;
    logic [CTRL_W-1:0] e_ctrl;
    int                e_sc, e_fc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic addRow(input logic r, v, input logic [7:0] rs, rt, rd, imm,
                        input logic [CTRL_W-1:0] ctrl, input logic br, busy, cc, es, ef, ev,
                        input logic [7:0] ers, erd, eimm, input logic [CTRL_W-1:0] ectrl,
                        input int esc, efc);
    vec_t t;
    t.rst = r; t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.imm = imm; t.ctrl = ctrl;
    t.br = br; t.busy = busy; t.chk_comb = cc; t.e_stall = es; t.e_flush = ef;
    t.e_valid = ev; t.e_rs = ers; t.e_rd = erd; t.e_imm = eimm; t.e_ctrl = ectrl;
    t.e_sc = esc; t.e_fc = efc;
    tbl.push_back(t);
  endtask

  task automatic applyStimulus(input logic r, v, input logic [RA_W-1:0] rs, rt, rd,
                               input logic [D_W-1:0] rsd, rtd, imm,
                               input logic [CTRL_W-1:0] ctrl, input logic br, busy);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
    ex_branch_taken = br; mem_busy = busy;
  endtask

  function automatic logic modelHazard();
    return m_valid && m_ctrl[C_MEM_READ] && (m_rd != 0) && id_valid &&
           ((m_rd == id_rs) || (m_rd == id_rt));
  endfunction

  function automatic logic modelStall();
    return mem_busy || (!ex_branch_taken && modelHazard());
  endfunction

  function automatic logic modelFlush();
    return !mem_busy && ex_branch_taken;
  endfunction

  task automatic modelBubble();
    m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rsd = 0; m_rtd = 0; m_imm = 0; m_ctrl = 0;
  endtask

  // Advance the model by one edge using the inputs that were applied for it
  task automatic modelStep(input logic hz);
    if (rst) begin
      modelBubble();
      m_sc = 0; m_fc = 0;
    end else if (mem_busy) begin
    end else if (ex_branch_taken) begin
      modelBubble();
      if (m_fc < CNT_MAX) m_fc++;
    end else if (hz) begin
      modelBubble();
      if (m_sc < CNT_MAX) m_sc++;
    end else begin
      m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm; m_ctrl = id_ctrl;
    end
  endtask

  task automatic checkOutput();
    check("ex_valid", ex_valid, m_valid);
    check("ex_rs", ex_rs, m_rs);
    check("ex_rt", ex_rt, m_rt);
    check("ex_rd", ex_rd, m_rd);
    check("ex_rs_data", ex_rs_data, m_rsd);
    check("ex_rt_data", ex_rt_data, m_rtd);
    check("ex_imm", ex_imm, m_imm);
    check("ex_ctrl", ex_ctrl, m_ctrl);
    check("stall_cnt", stall_cnt, 64'(m_sc));
    check("flush_cnt", flush_cnt, 64'(m_fc));
  endtask

  // One model-checked cycle: combinational outputs before the edge, registers after it
  task automatic cycle(input logic r, v, input logic [RA_W-1:0] rs, rt, rd,
                       input logic [D_W-1:0] rsd, rtd, imm,
                       input logic [CTRL_W-1:0] ctrl, input logic br, busy);
    logic hz;
    applyStimulus(r, v, rs, rt, rd, rsd, rtd, imm, ctrl, br, busy);
    #1;
    hz = modelHazard();
    if (!r) begin
      check("stall", stall, modelStall());
      check("if_id_flush", if_id_flush, modelFlush());
    end
    @(posedge clk);
    #1;
    modelStep(hz);
    checkOutput();
  endtask

  initial begin
    m_sc = 0; m_fc = 0;
    modelBubble();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //     rst v rs rt rd imm    ctrl br bz cc  st fl  ev rs rd imm    ctrl sc fc
    addRow(1, 0, 0, 0, 0, 8'h00, 0,   0, 0, 0,  0, 0,  0, 0, 0, 8'h00, 0,   0, 0);
    addRow(0, 1, 1, 2, 3, 8'h10, LD,  0, 0, 1,  0, 0,  1, 1, 3, 8'h10, LD,  0, 0);
    addRow(0, 1, 3, 4, 6, 8'h20, ALU, 0, 0, 1,  1, 0,  0, 0, 0, 8'h00, 0,   1, 0);
    addRow(0, 1, 3, 4, 6, 8'h20, ALU, 0, 0, 1,  0, 0,  1, 3, 6, 8'h20, ALU, 1, 0);
    addRow(0, 1, 1, 2, 0, 8'h30, LD,  0, 0, 1,  0, 0,  1, 1, 0, 8'h30, LD,  1, 0);
    addRow(0, 1, 0, 0, 3, 8'h31, ALU, 0, 0, 1,  0, 0,  1, 0, 3, 8'h31, ALU, 1, 0);
    addRow(0, 1, 3, 3, 7, 8'h32, ALU, 0, 0, 1,  0, 0,  1, 3, 7, 8'h32, ALU, 1, 0);
    addRow(0, 1, 1, 1, 9, 8'h40, LD,  0, 0, 1,  0, 0,  1, 1, 9, 8'h40, LD,  1, 0);
    addRow(0, 1, 2, 9, 4, 8'h41, ALU, 1, 0, 1,  0, 1,  0, 0, 0, 8'h00, 0,   1, 1);
    addRow(0, 1, 1, 2, 5, 8'h7F, LD,  0, 0, 1,  0, 0,  1, 1, 5, 8'h7F, LD,  1, 1);
    addRow(0, 1, 6, 7, 8, 8'h50, ALU, 0, 1, 1,  1, 0,  1, 1, 5, 8'h7F, LD,  1, 1);
    addRow(0, 1, 6, 7, 8, 8'h50, ALU, 1, 1, 1,  1, 0,  1, 1, 5, 8'h7F, LD,  1, 1);
    addRow(0, 1, 6, 7, 8, 8'h50, ALU, 0, 1, 1,  1, 0,  1, 1, 5, 8'h7F, LD,  1, 1);
    addRow(0, 1, 6, 7, 8, 8'h50, ALU, 0, 0, 1,  0, 0,  1, 6, 8, 8'h50, ALU, 1, 1);
    addRow(0, 1, 1, 1, 10,8'h60, LD,  0, 0, 1,  0, 0,  1, 1, 10,8'h60, LD,  1, 1);
    addRow(0, 1, 10,0, 2, 8'h70, ALU, 0, 1, 1,  1, 0,  1, 1, 10,8'h60, LD,  1, 1);
    addRow(1, 1, 10,0, 2, 8'h70, ALU, 0, 1, 0,  0, 0,  0, 0, 0, 8'h00, 0,   0, 0);
    addRow(0, 1, 10,0, 2, 8'h70, ALU, 0, 0, 1,  0, 0,  1, 10,2, 8'h70, ALU, 0, 0);
    addRow(0, 1, 1, 1, 3, 8'h71, LD,  0, 0, 1,  0, 0,  1, 1, 3, 8'h71, LD,  0, 0);
    addRow(1, 1, 3, 0, 4, 8'h72, ALU, 0, 0, 1,  1, 0,  0, 0, 0, 8'h00, 0,   0, 0);
    addRow(0, 1, 3, 0, 4, 8'h72, ALU, 0, 0, 1,  0, 0,  1, 3, 4, 8'h72, ALU, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      logic hz;
      applyStimulus(tbl[i].rst, tbl[i].v, RA_W'(tbl[i].rs), RA_W'(tbl[i].rt), RA_W'(tbl[i].rd),
                    tbl[i].imm + 8'd1, tbl[i].imm + 8'd2, tbl[i].imm, tbl[i].ctrl,
                    tbl[i].br, tbl[i].busy);
      #1;
      hz = modelHazard();
      if (tbl[i].chk_comb) begin
        check($sformatf("row%0d stall", i), stall, tbl[i].e_stall);
        check($sformatf("row%0d if_id_flush", i), if_id_flush, tbl[i].e_flush);
      end
      @(posedge clk);
      #1;
      modelStep(hz);
      check($sformatf("row%0d ex_valid", i), ex_valid, tbl[i].e_valid);
      check($sformatf("row%0d ex_rs", i), ex_rs, 64'(tbl[i].e_rs));
      check($sformatf("row%0d ex_rd", i), ex_rd, 64'(tbl[i].e_rd));
      check($sformatf("row%0d ex_imm", i), ex_imm, 64'(tbl[i].e_imm));
      check($sformatf("row%0d ex_ctrl", i), ex_ctrl, 64'(tbl[i].e_ctrl));
      check($sformatf("row%0d stall_cnt", i), stall_cnt, 64'(tbl[i].e_sc));
      check($sformatf("row%0d flush_cnt", i), flush_cnt, 64'(tbl[i].e_fc));
    end

    // Twenty load-use stalls must leave the stall counter pinned at its maximum
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      cycle(0, 1, 1, 2, 3, 8'h01, 8'h02, 8'(n), LD, 0, 0);
      cycle(0, 1, 3, 5, 6, 8'h03, 8'h04, 8'(n), ALU, 0, 0);
      cycle(0, 1, 3, 5, 6, 8'h03, 8'h04, 8'(n), ALU, 0, 0);
    end
    check("stall_cnt_saturated", stall_cnt, 64'd15);

    // Randomized traffic over a small register window so hazards are frequent
    for (int n = 0; n < 600; n++) begin
      logic v;
      logic [CTRL_W-1:0] c;
      v = ($urandom_range(3) != 0);
      c = CTRL_W'($urandom());
      c[C_MEM_READ] = $urandom_range(1);
      cycle(($urandom_range(63) == 0), v,
            RA_W'($urandom_range(3)), RA_W'($urandom_range(3)), RA_W'($urandom_range(3)),
            D_W'($urandom()), D_W'($urandom()), D_W'($urandom()),
            v ? c : '0, ($urandom_range(5) == 0), ($urandom_range(4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
